// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply, restoring divide.
// Each operation takes WIDTH+1 cycles. A divide by zero is rejected with a one-cycle flag.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFix, StZero} state_e;

  state_e r_state, w_state_next;

  logic [CntW-1:0]  r_cnt;
  logic [WIDTH:0]   r_acc;    // Booth accumulator / partial remainder
  logic [WIDTH-1:0] r_q;      // multiplier / dividend, shifted into product low / quotient
  logic [WIDTH-1:0] r_b;      // multiplicand / divisor magnitude
  logic             r_qm1;
  logic             r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_booth_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_diff;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_last     = (r_cnt == CntLast);
  assign w_a_mag    = a_in[WIDTH-1] ? -a_in : a_in;
  assign w_b_mag    = b_in[WIDTH-1] ? -b_in : b_in;
  assign w_m_ext    = {r_b[WIDTH-1], r_b};
  assign w_rem_sh   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_quo_fix  = r_neg_q ? -r_q : r_q;
  assign w_rem_fix  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  // Accumulator is one bit wider so that subtracting the most negative multiplicand cannot wrap.
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if (!op) begin
            w_state_next = StMult;
          end else if (b_in == '0) begin
            w_state_next = StZero;
          end else begin
            w_state_next = StDiv;
          end
        end
      end
      StMult, StDiv: begin
        if (w_last) begin
          w_state_next = StFix;
        end
      end
      StFix:   w_state_next = StIdle;
      StZero:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    div_zero = 1'b0;
    case (r_state)
      StMult, StDiv, StFix: busy     = 1'b1;
      StZero:               div_zero = 1'b1;
      default: ;
    endcase
  end

  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_qm1   <= 1'b0;
      r_op    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_op    <= op;
            r_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_r <= a_in[WIDTH-1];
            if (!op) begin
              r_q <= a_in;
              r_b <= b_in;
            end else begin
              r_q <= w_a_mag;
              r_b <= w_b_mag;
            end
          end
        end
        StMult: begin
          r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
          r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CntW'(1);
        end
        StDiv: begin
          // Negative trial difference means the divisor did not fit: restore.
          r_acc <= w_rem_diff[WIDTH] ? w_rem_sh : w_rem_diff;
          r_q   <= {r_q[WIDTH-2:0], ~w_rem_diff[WIDTH]};
          r_cnt <= r_cnt + CntW'(1);
        end
        StFix: begin
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= r_q;
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: an arithmetic timeline model checked every cycle,
// directed corner cases pinned to literal values, then randomized operations.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an accepted op completes WIDTH+1 clocks later with the arithmetic result.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_done, m_dz;
  int           m_cnt;
  bit           m_live = 1'b0;
  bit           m_idle;
  longint       sa, sb, pr;

  task automatic model_step();
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_cnt = 0; m_live = 1'b1;
    end else begin
      m_idle = (m_cnt == 0) && !m_dz;
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end else if (m_idle && start) begin
        sa = longint'($signed(a_in));
        sb = longint'($signed(b_in));
        if (!op) begin
          pr = sa * sb;
          {p_hi, p_lo} = pr;
          m_cnt = W + 1;
        end else if (sb == 0) begin
          m_dz = 1'b1;
        end else begin
          p_lo  = W'(sa / sb);
          p_hi  = W'(sa % sb);
          m_cnt = W + 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("busy", busy, (m_cnt > 0));
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
    end
  end

  // Launch one op. Returns the number of clocks from the start edge until done (0 for div-by-zero).
  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit junk, input int inject_at, output int lat);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = -1;
    if (o && b == '0) begin
      chk("dz_pulse", div_zero, 1);
      chk("dz_nobusy", busy, 0);
      chk("dz_nodone", done, 0);
      @(posedge clk); #1;
      chk("dz_end", div_zero, 0);
      lat = 0;
    end else begin
      for (int k = 1; k <= W + 8; k++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = k;
          break;
        end
        if (k == inject_at || (junk && $urandom_range(0, 7) == 0)) begin
          start = 1'b1; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      if (lat < 0) chk("done_timeout", done, 1);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int  lat;
  bit  seen_done;

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, -1, lat);
    chk("mul7x-3_lat", lat, 33);
    chk("mul7x-3_busy", busy, 0);
    chk("mul7x-3_hi", hi_out, 32'hFFFF_FFFF);
    chk("mul7x-3_lo", lo_out, 32'hFFFF_FFEB);

    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, lat);
    chk("mulmin_hi", hi_out, 32'h4000_0000);
    chk("mulmin_lo", lo_out, 32'h0000_0000);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, lat);
    chk("div-7/2_lat", lat, 33);
    chk("div-7/2_lo", lo_out, 32'hFFFF_FFFD);
    chk("div-7/2_hi", hi_out, 32'hFFFF_FFFF);

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, -1, lat);
    chk("div7/-2_lo", lo_out, 32'hFFFF_FFFD);
    chk("div7/-2_hi", hi_out, 32'h0000_0001);

    run_op(1'b1, 32'h0000_2211, 32'h0000_0100, 1'b0, -1, lat);
    chk("preload_hi", hi_out, 32'h11);
    chk("preload_lo", lo_out, 32'h22);
    run_op(1'b1, 32'd5, 32'd0, 1'b0, -1, lat);
    chk("div0_hi", hi_out, 32'h11);
    chk("div0_lo", lo_out, 32'h22);

    run_op(1'b0, 32'd1234, 32'd5678, 1'b0, 10, lat);
    chk("inject_lat", lat, 33);
    chk("inject_hi", hi_out, 32'd0);
    chk("inject_lo", lo_out, 32'd7006652);

    start = 1'b1; op = 1'b0; a_in = 32'd99; b_in = 32'd77;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    seen_done = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1 seen_done |= done;
    end
    chk("midrst_no_done", seen_done, 0);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, lat);
    chk("divovf_lo", lo_out, 32'h8000_0000);
    chk("divovf_hi", hi_out, 32'h0000_0000);

    repeat (200) begin
      run_op(1'($urandom), pick(), pick(), 1'b1, -1, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
